// File: rtl/proc_sequencer.sv
// proc_sequencer
//   Instruction source for simple8BitProcessor. Holds up to DEPTH
//   (func, immediate) entries, issues one entry per clock on func/dataIn
//   once started, then drains with NOPs so that every store issued near the
//   end of the program still gets its dataOut captured. Each issued store
//   produces one storeValid pulse carrying the processor's dataOut.
//
// Parameters
//   DEPTH      program entries
//   AW         program address width, log2(DEPTH)
//   STORE_LAT  cycles from the store-issue edge until dataOut is valid
//
// Ports
//   clock, resetN            clock, synchronous active-low reset
//   progWe/progAddr/         program write port, ignored while busy
//   progFunc/progData
//   progLen                  entry count, sampled on accepted start,
//                            values above DEPTH clamp to DEPTH
//   start                    begin execution from entry 0 (IDLE only)
//   busy, done               run/drain indicator, end-of-program pulse
//   pc                       index of the entry currently on func
//   func, dataIn             instruction word and immediate to processor
//   dataOut                  result bus from processor
//   storeValid, storeData    captured store result and its strobe
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | NOP on func, waiting for start
// RUN   | entry[pc] on func/dataIn, pc advances every cycle
// DRAIN | NOP for STORE_LAT+1 cycles while late store captures finish
// DONE  | one-cycle done pulse, back to IDLE

module proc_sequencer #(
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int STORE_LAT = 1
) (
   input  logic          clock,
   input  logic          resetN,
   input  logic          progWe,
   input  logic [AW-1:0] progAddr,
   input  logic [8:0]    progFunc,
   input  logic [7:0]    progData,
   input  logic [AW:0]   progLen,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] pc,
   output logic [8:0]    func,
   output logic [7:0]    dataIn,
   input  logic [7:0]    dataOut,
   output logic          storeValid,
   output logic [7:0]    storeData
);

   localparam logic [8:0]  NOP      = 9'b001_000_000;
   localparam logic [2:0]  OP_STORE = 3'b111;
   localparam int          DW       = (STORE_LAT < 1) ? 1 : $clog2(STORE_LAT + 1);
   localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [16:0]     prog_mem [DEPTH];
   logic [AW:0]     len_q, len_nxt, len_eff;
   logic [AW-1:0]   pc_nxt, pc_inc;
   logic [8:0]      func_nxt;
   logic [7:0]      data_nxt;
   logic [DW-1:0]   drain_cnt, drain_nxt;
   logic            busy_nxt;
   logic            last_entry;
   logic [STORE_LAT-1:0] st_pipe;

   assign len_eff    = (progLen > DEPTH_W) ? DEPTH_W : progLen;
   assign pc_inc     = pc + AW'(1);
   assign last_entry = ({1'b0, pc} == (len_q - (AW+1)'(1)));
   assign done       = (state == S_DONE);

   // Program memory has no reset: a loaded program survives a reset.
   always_ff @(posedge clock) begin
      if (progWe && !busy) begin
         prog_mem[progAddr] <= {progFunc, progData};
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      func_nxt  = NOP;
      data_nxt  = '0;
      len_nxt   = len_q;
      drain_nxt = drain_cnt;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (len_eff != '0) begin
                  state_nxt = S_RUN;
                  pc_nxt    = '0;
                  func_nxt  = prog_mem[0][16:8];
                  data_nxt  = prog_mem[0][7:0];
                  len_nxt   = len_eff;
               end else begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (last_entry) begin
               state_nxt = S_DRAIN;
               drain_nxt = DW'(STORE_LAT);
            end else begin
               pc_nxt   = pc_inc;
               func_nxt = prog_mem[pc_inc][16:8];
               data_nxt = prog_mem[pc_inc][7:0];
            end
         end
         S_DRAIN: begin
            // Down-counter loaded with STORE_LAT gives STORE_LAT+1 drain cycles.
            if (drain_cnt == '0) begin
               state_nxt = S_DONE;
            end else begin
               drain_nxt = drain_cnt - DW'(1);
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      busy_nxt = (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state     <= S_IDLE;
         pc        <= '0;
         func      <= NOP;
         dataIn    <= '0;
         busy      <= 1'b0;
         len_q     <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         func      <= func_nxt;
         dataIn    <= data_nxt;
         busy      <= busy_nxt;
         len_q     <= len_nxt;
         drain_cnt <= drain_nxt;
      end
   end

   // A store on func in cycle N reaches the end of the flag pipe in cycle
   // N+STORE_LAT, which is exactly when the processor's dataOut is valid.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         st_pipe    <= '0;
         storeValid <= 1'b0;
         storeData  <= '0;
      end else begin
         st_pipe[0] <= (func[8:6] == OP_STORE);
         for (int i = 1; i < STORE_LAT; i++) begin
            st_pipe[i] <= st_pipe[i-1];
         end
         storeValid <= st_pipe[STORE_LAT-1];
         if (st_pipe[STORE_LAT-1]) begin
            storeData <= dataOut;
         end
      end
   end

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer. A small processor model answers store
// instructions on dataOut one cycle late and drives noise otherwise. A
// program-level reference interpreter predicts the func stream, the store
// results with their cycles, and the busy/done windows; a monitor at the
// falling edge compares the DUT against those predictions.

module tb_proc_sequencer;

   localparam int DEPTH     = 16;
   localparam int AW        = 4;
   localparam int STORE_LAT = 1;
   localparam logic [8:0] NOP = 9'b001_000_000;

   logic          clock = 1'b0;
   logic          resetN = 1'b0;
   logic          progWe = 1'b0;
   logic [AW-1:0] progAddr = '0;
   logic [8:0]    progFunc = '0;
   logic [7:0]    progData = '0;
   logic [AW:0]   progLen = '0;
   logic          start = 1'b0;
   logic          busy, done, storeValid;
   logic [AW-1:0] pc;
   logic [8:0]    func;
   logic [7:0]    dataIn, storeData;
   logic [7:0]    dataOut = '0;

   proc_sequencer #(.DEPTH(DEPTH), .AW(AW), .STORE_LAT(STORE_LAT)) dut (
      .clock(clock), .resetN(resetN), .progWe(progWe), .progAddr(progAddr),
      .progFunc(progFunc), .progData(progData), .progLen(progLen),
      .start(start), .busy(busy), .done(done), .pc(pc), .func(func),
      .dataIn(dataIn), .dataOut(dataOut), .storeValid(storeValid),
      .storeData(storeData)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clock) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] imm);
      case (op)
         3'd0:    return imm;
         3'd1:    return b;
         3'd2:    return a + b;
         3'd3:    return a - b;
         3'd4:    return a & b;
         3'd5:    return a | b;
         3'd6:    return a ^ b;
         default: return a;
      endcase
   endfunction

   function automatic logic [8:0] enc(input int op, input int rd, input int rs);
      return {3'(op), 3'(rd), 3'(rs)};
   endfunction

   // processor model
   logic [7:0] proc_regs [8];
   bit         pend = 0;
   logic [7:0] pend_val = '0;

   always @(negedge clock) begin
      dataOut = pend ? pend_val : 8'($urandom);
      if (!$isunknown(func)) begin
         if (func[8:6] == 3'b111) begin
            pend     = 1;
            pend_val = proc_regs[func[5:3]];
         end else begin
            pend = 0;
            proc_regs[func[5:3]] = alu(func[8:6], proc_regs[func[5:3]],
                                       proc_regs[func[2:0]], dataIn);
         end
      end else begin
         pend = 0;
      end
   end

   // reference state
   logic [8:0] ref_f [DEPTH];
   logic [7:0] ref_d [DEPTH];
   logic [7:0] ref_regs [8];

   typedef struct {int c; logic [8:0] f; logic [7:0] d; logic [AW-1:0] p;} fitem_t;
   typedef struct {int c; logic [7:0] v;} sitem_t;
   fitem_t fq[$];
   sitem_t sq[$];
   int busy_lo = 1, busy_hi = 0, done_cyc = -1;
   bit mon_on = 0;

   // scoreboard monitor
   always @(negedge clock) begin
      fitem_t     fi;
      sitem_t     si;
      logic [8:0] ef;
      logic [7:0] ed;
      if (mon_on) begin
         ef = NOP;
         ed = '0;
         if (fq.size() > 0 && fq[0].c == cyc) begin
            fi = fq.pop_front();
            ef = fi.f;
            ed = fi.d;
            chk("pc", 32'(pc), 32'(fi.p));
         end
         chk("func", 32'(func), 32'(ef));
         chk("dataIn", 32'(dataIn), 32'(ed));
         chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
         chk("done", 32'(done), 32'(cyc == done_cyc));
         if (sq.size() > 0 && sq[0].c == cyc) begin
            si = sq.pop_front();
            chk("storeValid", 32'(storeValid), 32'd1);
            chk("storeData", 32'(storeData), 32'(si.v));
         end else begin
            chk("storeValid", 32'(storeValid), 32'd0);
         end
      end
   end

   task automatic write_entry(input int addr, input logic [8:0] f, input logic [7:0] d);
      @(posedge clock); #1;
      progWe   = 1'b1;
      progAddr = AW'(addr);
      progFunc = f;
      progData = d;
      @(posedge clock); #1;
      progWe = 1'b0;
      ref_f[addr] = f;
      ref_d[addr] = d;
   endtask

   // abort_at >= 0: reset is asserted in the cycle that issues entry abort_at-1.
   // poke: start and a program write are attempted mid-run.
   task automatic launch(input int req, input int abort_at, input bit poke);
      int k, eff, guard;
      bit ab;
      fitem_t fi;
      sitem_t si;
      @(posedge clock); #1;
      k       = cyc;
      start   = 1'b1;
      progLen = (AW+1)'(req);
      eff     = (req > DEPTH) ? DEPTH : req;
      ab      = (abort_at >= 0);
      for (int i = 0; i < eff; i++) begin
         if (ab && i >= abort_at) break;
         fi.c = k + 1 + i; fi.f = ref_f[i]; fi.d = ref_d[i]; fi.p = AW'(i);
         fq.push_back(fi);
         if (ref_f[i][8:6] == 3'b111) begin
            if (!ab || (k + 3 + i) <= (k + abort_at)) begin
               si.c = k + 3 + i;
               si.v = ref_regs[ref_f[i][5:3]];
               sq.push_back(si);
            end
         end else begin
            ref_regs[ref_f[i][5:3]] = alu(ref_f[i][8:6], ref_regs[ref_f[i][5:3]],
                                          ref_regs[ref_f[i][2:0]], ref_d[i]);
         end
      end
      if (eff == 0) begin
         busy_lo = 1; busy_hi = 0; done_cyc = k + 1;
      end else if (ab) begin
         busy_lo = k + 1; busy_hi = k + abort_at; done_cyc = -1;
      end else begin
         busy_lo = k + 1; busy_hi = k + eff + 2; done_cyc = k + eff + 3;
      end
      @(posedge clock); #1;
      start = 1'b0;
      if (poke) begin
         @(posedge clock); #1;
         start    = 1'b1;
         progLen  = (AW+1)'(2);
         progWe   = 1'b1;
         progAddr = '0;
         progFunc = ~ref_f[0];
         progData = ~ref_d[0];
         @(posedge clock); #1;
         start  = 1'b0;
         progWe = 1'b0;
      end
      if (ab) begin
         repeat (abort_at - 1) begin @(posedge clock); #1; end
         resetN = 1'b0;
         @(posedge clock); #1;
         resetN = 1'b1;
         chk("pc_after_reset", 32'(pc), 32'd0);
         repeat (3) begin @(posedge clock); #1; end
      end
      guard = 0;
      while (cyc <= done_cyc && guard < 100) begin
         @(posedge clock); #1;
         guard++;
      end
      chk("run_timeout", 32'(guard >= 100), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         proc_regs[i] = '0;
         ref_regs[i]  = '0;
      end
      repeat (3) @(posedge clock);
      #1;
      chk("rst_func", 32'(func), 32'(NOP));
      chk("rst_dataIn", 32'(dataIn), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_storeValid", 32'(storeValid), 32'd0);
      chk("rst_storeData", 32'(storeData), 32'd0);
      resetN = 1'b1;
      mon_on = 1;

      // xor program, store result 15
      write_entry(0, enc(0, 1, 0), 8'd10);
      write_entry(1, enc(0, 0, 0), 8'd5);
      write_entry(2, enc(6, 0, 1), 8'd0);
      write_entry(3, enc(7, 0, 0), 8'd0);
      launch(4, -1, 0);

      // two stores in one program: 3 then 14
      write_entry(0, enc(0, 2, 0), 8'd1);
      write_entry(1, enc(0, 3, 0), 8'd2);
      write_entry(2, enc(2, 2, 3), 8'd0);
      write_entry(3, enc(7, 2, 0), 8'd0);
      write_entry(4, enc(0, 4, 0), 8'd8);
      write_entry(5, enc(0, 5, 0), 8'd6);
      write_entry(6, enc(5, 4, 5), 8'd0);
      write_entry(7, enc(7, 4, 0), 8'd0);
      launch(8, -1, 0);

      // back-to-back stores, both 7
      write_entry(0, enc(0, 6, 0), 8'd7);
      write_entry(1, enc(1, 7, 6), 8'd0);
      write_entry(2, enc(7, 7, 0), 8'd0);
      write_entry(3, enc(7, 6, 0), 8'd0);
      launch(4, -1, 0);

      // empty program
      launch(0, -1, 0);

      // start/progWe while busy are ignored, rerun matches
      write_entry(0, enc(0, 1, 0), 8'd10);
      write_entry(1, enc(0, 0, 0), 8'd5);
      write_entry(2, enc(6, 0, 1), 8'd0);
      write_entry(3, enc(7, 0, 0), 8'd0);
      launch(4, -1, 1);
      launch(4, -1, 0);

      // reset in cycle 2 with a store in flight, then a clean run
      write_entry(0, enc(0, 1, 0), 8'd9);
      write_entry(1, enc(7, 1, 0), 8'd0);
      write_entry(2, enc(0, 2, 0), 8'd3);
      write_entry(3, enc(7, 2, 0), 8'd0);
      launch(4, 2, 0);
      launch(4, -1, 0);

      // full depth and clamped length
      for (int i = 0; i < DEPTH; i++)
         write_entry(i, enc($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
                     8'($urandom));
      launch(DEPTH, -1, 0);
      launch(25, -1, 0);

      // random programs
      for (int n = 0; n < 25; n++) begin
         int req, eff;
         req = ($urandom_range(0, 4) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
         eff = (req > DEPTH) ? DEPTH : req;
         for (int i = 0; i < eff; i++)
            write_entry(i, enc($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
                        8'($urandom));
         launch(req, -1, 0);
      end

      repeat (4) @(posedge clock);
      #1;
      chk("func_queue_left", 32'(fq.size()), 32'd0);
      chk("store_queue_left", 32'(sq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
